hack_ram: RTL and testbench

Parametrised single-port synchronous RAM for the Hack memory hierarchy, the generalised successor of the fixed 4K×16 RAM. Word width and depth are parameters. A built-in clear sequencer zeroes the whole array after reset or on request, and reports `busy` while it runs. It serves as the data-memory building block for RAM16K and for the CPU-facing memory map.

---
 rtl/hack_mem_pkg.sv | 12 +
 rtl/ram_clear_seq.sv | 62 ++++++
 rtl/hack_ram.sv | 71 +++++++
 tb/tb_hack_ram.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared types and default sizes for the Hack memory building blocks.
package hack_mem_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } hack_ram_state_t;

  localparam int HACK_WORD_W     = 16;
  localparam int HACK_RAM_ADDR_W = 12;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer for hack_ram: owns the FSM, the sweep counter and busy.
// The clear write strobe is suppressed on reset edges so reset never writes the array.
module ram_clear_seq
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W = HACK_RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              clear_i,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              idle_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  hack_ram_state_t   state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              busy_q;

  // Natural wrap brings the counter back to 0 on the final sweep edge.
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_i) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we_o   = (state_q == ST_CLEAR) && !reset_i;
  assign clr_addr_o = cnt_q;
  assign idle_o     = (state_q == ST_IDLE);
  assign busy_o     = busy_q;

endmodule

// File: rtl/hack_ram.sv
// Parametrised single-port Hack RAM with a self-clearing sweep after reset or clear.
// Define HACK_RAM_WRITE_THROUGH_EN for write-first reads; default is read-first.
module hack_ram
  import hack_mem_pkg::*;
#(
  parameter int WIDTH  = HACK_WORD_W,
  parameter int ADDR_W = HACK_RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef HACK_RAM_WRITE_THROUGH_EN
  localparam bit WRITE_THROUGH = 1'b1;
`else
  localparam bit WRITE_THROUGH = 1'b0;
`endif

  logic [WIDTH-1:0]  ram_q [DEPTH];
  logic [WIDTH-1:0]  out_q;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle;
  logic              user_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  ram_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk        (clk),
    .reset_i    (reset),
    .clear_i    (clear),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .idle_o     (idle),
    .busy_o     (busy)
  );

  // A user access only counts in idle, and a same-edge clear request wins.
  assign user_acc = idle && !clear && !reset;
  assign wr_en    = clr_we || (user_acc && load);
  assign wr_addr  = clr_we ? clr_addr : address;
  assign wr_data  = clr_we ? '0 : in;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!user_acc) begin
      out_q <= '0;
    end else if (WRITE_THROUGH && load) begin
      out_q <= in;
    end else begin
      out_q <= ram_q[address];
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_hack_ram.sv
// Self-checking bench for hack_ram: a 16x16 and a 64x8 instance driven in lockstep
// and compared every edge against a behavioural memory model.
module tb_hack_ram;

`ifdef HACK_RAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        load  = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] din   = '0;
  logic [5:0]  addr  = '0;
  logic [15:0] out_a;
  logic        busy_a;
  logic [7:0]  out_b;
  logic        busy_b;

  hack_ram #(.WIDTH(16), .ADDR_W(4)) dut_a (
    .clk(clk), .reset(reset), .in(din), .address(addr[3:0]),
    .load(load), .clear(clear), .out(out_a), .busy(busy_a)
  );

  hack_ram #(.WIDTH(8), .ADDR_W(6)) dut_b (
    .clk(clk), .reset(reset), .in(din[7:0]), .address(addr),
    .load(load), .clear(clear), .out(out_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Model: memory contents, remaining sweep edges and expected out per instance.
  logic [15:0] mem [2][64];
  int          busy_left [2];
  logic [15:0] exp_out [2];
  int          depth [2];
  logic [15:0] mask [2];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int a;
      logic [15:0] old;
      a = int'(addr) % depth[k];
      if (reset) begin
        busy_left[k] = depth[k];
        exp_out[k]   = '0;
      end else if (busy_left[k] > 0) begin
        busy_left[k]--;
        exp_out[k] = '0;
        if (busy_left[k] == 0)
          for (int i = 0; i < depth[k]; i++) mem[k][i] = '0;
      end else if (clear) begin
        busy_left[k] = depth[k];
        exp_out[k]   = '0;
      end else begin
        old = mem[k][a];
        if (load) mem[k][a] = din & mask[k];
        exp_out[k] = (WT && load) ? (din & mask[k]) : old;
      end
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic cl,
                      input logic [5:0] a, input logic [15:0] d);
    reset = r; load = ld; clear = cl; addr = a; din = d;
    @(posedge clk);
    #1;
    step_no++;
    model_edge();
    check("out_a",  out_a,  exp_out[0]);
    check("busy_a", {15'b0, busy_a}, {15'b0, busy_left[0] != 0});
    check("out_b",  {8'b0, out_b}, exp_out[1]);
    check("busy_b", {15'b0, busy_b}, {15'b0, busy_left[1] != 0});
    $display("step %0d rst=%b ld=%b clr=%b addr=%0d din=%h | a: out=%h busy=%b | b: out=%h busy=%b",
             step_no, r, ld, cl, a, d, out_a, busy_a, out_b, busy_b);
  endtask

  initial begin
    depth[0] = 16;  mask[0] = 16'hFFFF;
    depth[1] = 64;  mask[1] = 16'h00FF;
    busy_left[0] = 0; busy_left[1] = 0;
    exp_out[0] = '0;  exp_out[1] = '0;

    // Reset sweep; accesses during it are attempted and must be dropped.
    step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 64; i++)
      step(1'b0, (i == 3), 1'b0, 6'd2, 16'h1111);
    for (int i = 0; i < 64; i++)
      step(1'b0, 1'b0, 1'b0, 6'(i), 16'h0);

    // Write/read latency.
    step(1'b0, 1'b1, 1'b0, 6'd3, 16'hBEEF);
    step(1'b0, 1'b0, 1'b0, 6'd3, 16'h0);
    step(1'b0, 1'b0, 1'b0, 6'd4, 16'h0);

    // Read during write.
    step(1'b0, 1'b1, 1'b0, 6'd5, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 6'd5, 16'h5678);
    step(1'b0, 1'b0, 1'b0, 6'd5, 16'h0);

    // Fill, then clear with a simultaneous load that must lose.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 1'b0, 6'(i), 16'hA5A5);
    step(1'b0, 1'b1, 1'b1, 6'd7, 16'hFFFF);
    for (int i = 0; i < 64; i++)
      step(1'b0, 1'b1, (i == 5), 6'd2, 16'h1111);
    for (int i = 0; i < 64; i++)
      step(1'b0, 1'b0, 1'b0, 6'(i), 16'h0);

    // Reset mid-sweep at cnt=9.
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 6'(i), 16'h3C3C);
    step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 66; i++)
      step(1'b0, 1'b0, 1'b0, 6'(i % 64), 16'h0);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0),
           6'($urandom_range(0, 63)), 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
